result_display: RTL

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/result_display.sv
// Purpose: scans a 4-digit 7-seg display showing |data|, sign, add/sub mode and overflow.
// Latency: inputs registered once, seg/an registered once more (2 clocks); led_ov 2 clocks.
// Backpressure: none; the scan counter free-runs and never stalls on input changes.
module result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data,
    input  logic       OV,
    input  logic       cm1,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       led_ov
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // Segment patterns, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_O     = 7'b0100011;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } dig_sel_e;

    // Registered input copies; all decoding works from these only.
    logic [3:0] data_q;
    logic       ov_q;
    logic       cm1_q;

    // Scan state.
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    dig_sel_e      sel_q, sel_d;

    // Overflow blink state; phase 1 means digits 0/1 are lit.
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    // Output registers, so anode and cathode change on the same edge.
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       led_q;

    // Decode helpers.
    logic [3:0] mag;
    logic [6:0] mag_seg;
    logic       blank_low;

    // Decimal digit 0..8 to segment pattern; out-of-range values show blank.
    function automatic logic [6:0] digit_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Sample the adder outputs every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 4'd0;
            ov_q   <= 1'b0;
            cm1_q  <= 1'b0;
        end else begin
            data_q <= data;
            ov_q   <= OV;
            cm1_q  <= cm1;
        end
    end

    // Refresh counter and digit select next state; advances select on each wrap.
    always_comb begin
        ref_cnt_d = ref_cnt_q + RW'(1);
        sel_d     = sel_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            case (sel_q)
                DIG0:    sel_d = DIG1;
                DIG1:    sel_d = DIG2;
                DIG2:    sel_d = DIG3;
                default: sel_d = DIG0;
            endcase
        end
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            sel_q     <= DIG0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            sel_q     <= sel_d;
        end
    end

    // Blink counter runs only during overflow; otherwise parked with the phase on.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        if (ov_q) begin
            phase_d = phase_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Blink state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Digit content: magnitude (1000 wraps to itself and reads as 8), sign, mode, overflow.
    always_comb begin
        mag       = data_q[3] ? (~data_q + 4'd1) : data_q;
        mag_seg   = digit_seg(mag);
        blank_low = ov_q && !phase_q;
        an_d      = 4'b1110;
        seg_d     = SEG_BLANK;
        case (sel_q)
            DIG0: begin
                an_d  = 4'b1110;
                seg_d = blank_low ? SEG_BLANK : mag_seg;
            end
            DIG1: begin
                an_d  = 4'b1101;
                seg_d = (blank_low || !data_q[3]) ? SEG_BLANK : SEG_DASH;
            end
            DIG2: begin
                an_d  = 4'b1011;
                seg_d = cm1_q ? SEG_S : SEG_A;
            end
            default: begin
                an_d  = 4'b0111;
                seg_d = ov_q ? SEG_O : SEG_BLANK;
            end
        endcase
    end

    // Output registers; reset forces all digits dark and the LED off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1111;
            seg_q <= SEG_BLANK;
            led_q <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            led_q <= ov_q;
        end
    end

    assign an     = an_q;
    assign seg    = seg_q;
    assign led_ov = led_q;
    assign dp     = 1'b1;

endmodule
